serial_pattern_gen: RTL



---
 rtl/serial_gen_pkg.sv | 15 +
 rtl/pattern_shifter.sv | 40 ++++
 rtl/serial_pattern_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_gen_pkg.sv
// serial_gen_pkg: shared state encoding, default widths and transfer-length helper
package serial_gen_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;

    // Number of cycles with out_valid=1 for one transfer (gaps only between instances)
    function automatic int xfer_cycles(input int pat_w, input int reps, input int gap);
        return (reps == 0) ? 0 : (pat_w + gap) * reps - gap;
    endfunction

endpackage

// File: rtl/pattern_shifter.sv
// pattern_shifter: loadable MSB-first rotating shift register with bit index and last flag
module pattern_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb,
    output logic             last
);

    localparam int IW = $clog2(PAT_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(PAT_W - 1);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [IW-1:0]    idx_q, idx_d;

    // Rotate rather than shift so the pattern is intact again after every instance
    always_comb begin
        sr_d  = load ? din : shift ? {sr_q[PAT_W-2:0], sr_q[PAT_W-1]} : sr_q;
        idx_d = load ? '0 : shift ? ((idx_q == LAST_IDX) ? '0 : idx_q + IW'(1)) : idx_q;
    end

    // Register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb  = sr_q[PAT_W-1];
    assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: repeats a latched pattern MSB-first with optional fill gaps between instances
module serial_pattern_gen
    import serial_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             gap_bit,
    output logic             out,
    output logic             out_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             gap_bit_q, gap_bit_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sh_load, sh_msb, sh_last;

    assign sh_load = (state_q == IDLE) && start;

    pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (state_q == SEND),
        .din   (pattern),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    // Next state, counters and output values; outputs are a registered image of the current state
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        gap_cnt_d   = gap_cnt_q;
        gap_len_d   = gap_len_q;
        gap_bit_d   = gap_bit_q;
        out_d       = (state_q == SEND) ? sh_msb : (state_q == GAP) ? gap_bit_q : 1'b0;
        out_valid_d = (state_q == SEND) || (state_q == GAP);
        last_d      = (state_q == SEND) && sh_last;
        busy_d      = (state_q == SEND) || (state_q == GAP);
        done_d      = (state_q == FIN);
        case (state_q)
            IDLE: if (start) begin
                gap_len_d = gap_len;
                gap_bit_d = gap_bit;
                rem_d     = repeats;
                state_d   = (repeats == '0) ? FIN : SEND;
            end
            SEND: if (sh_last) begin
                rem_d     = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
                gap_cnt_d = gap_len_q;
                state_d   = (rem_q <= CNT_W'(1)) ? FIN : (gap_len_q != '0) ? GAP : SEND;
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                state_d   = (gap_cnt_q == GAP_W'(1)) ? SEND : GAP;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            gap_cnt_q   <= '0;
            gap_len_q   <= '0;
            gap_bit_q   <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_len_q   <= gap_len_d;
            gap_bit_q   <= gap_bit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign last_bit  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
